// File: rtl/data_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Each transaction runs IDLE -> ACCESS -> RESP, so the memory sees one access per pass.
module data_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_A_in,
  output logic [DW-1:0] mem_D_in,
  output logic          mem_WE,
  input  logic [DW-1:0] mem_D_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_reg;
  logic   grant_reg;
  logic   last_grant_reg;
  logic   winner;

  // A tie goes to whoever did not win last; a lone request always wins.
  always_comb begin
    winner = 1'b0;
    if (m0_req && m1_req) begin
      winner = ~last_grant_reg;
    end else if (m1_req) begin
      winner = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      m0_ack         <= 1'b0;
      m1_ack         <= 1'b0;
      m0_rdata       <= '0;
      m1_rdata       <= '0;
      mem_WE         <= 1'b0;
      mem_A_in       <= '0;
      mem_D_in       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (m0_req || m1_req) begin
            state_reg      <= ACCESS;
            grant_reg      <= winner;
            last_grant_reg <= winner;
            // Memory controls are registered so they are valid for the whole ACCESS cycle.
            mem_WE         <= winner ? m1_we    : m0_we;
            mem_A_in       <= winner ? m1_addr  : m0_addr;
            mem_D_in       <= winner ? m1_wdata : m0_wdata;
          end
        end
        ACCESS: begin
          state_reg <= RESP;
          mem_WE    <= 1'b0;
          mem_A_in  <= '0;
          mem_D_in  <= '0;
          // mem_WE still holds the granted write enable here, so low means a read.
          if (!mem_WE) begin
            if (grant_reg) begin
              m1_rdata <= mem_D_out;
            end else begin
              m0_rdata <= mem_D_out;
            end
          end
          if (grant_reg) begin
            m1_ack <= 1'b1;
          end else begin
            m0_ack <= 1'b1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
          m0_ack    <= 1'b0;
          m1_ack    <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          m0_ack    <= 1'b0;
          m1_ack    <= 1'b0;
          mem_WE    <= 1'b0;
          mem_A_in  <= '0;
          mem_D_in  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: scenario tasks plus randomized traffic against a
// transaction-level model (round-robin order, 3-cycle passes, shadow memory).
`timescale 1ns/1ps
module tb_data_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] mem_A_in;
  logic [DW-1:0] mem_D_in, mem_D_out;
  logic          mem_WE;
  logic          mem_clear = 1'b1;
  logic [DW-1:0] mem_array [16];

  data_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_A_in(mem_A_in), .mem_D_in(mem_D_in), .mem_WE(mem_WE), .mem_D_out(mem_D_out)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, write on rising edge.
  assign mem_D_out = mem_array[mem_A_in[3:0]];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 16; i++) mem_array[i] <= '0;
    end else if (mem_WE) begin
      mem_array[mem_A_in[3:0]] <= mem_D_in;
    end
  end

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1;
  } obs_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          ack0;
    logic          ack1;
    logic          upd0;
    logic          upd1;
    logic [DW-1:0] rdv;
    logic          wr;
    logic [3:0]    wa;
    logic [DW-1:0] wv;
  } slot_t;

  txn_t          q0[$], q1[$];
  slot_t         ring [4];
  logic [DW-1:0] shadow [16];
  logic [DW-1:0] exp_rd0, exp_rd1;
  obs_t          exp_now;
  int            cyc, idle_at;
  bit            last_win, eager;
  int            checks, errors;
  int            ack_who[$], ack_cyc[$];
  int            we_cycles;

  function automatic obs_t observe();
    return {mem_WE, mem_A_in, mem_D_in, m0_ack, m1_ack, m0_rdata, m1_rdata};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) ring[i] = '0;
    q0.delete(); q1.delete();
    ack_who.delete(); ack_cyc.delete();
    exp_rd0 = '0; exp_rd1 = '0; exp_now = '0;
    last_win = 1'b1;
    idle_at = cyc;
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  // Drive requesters for the current cycle, advance the model, then step to the next negedge.
  task automatic advance();
    txn_t t;
    bit   w;
    int   s;
    if (m0_ack === 1'b1) begin ack_who.push_back(0); ack_cyc.push_back(cyc); end
    if (m1_ack === 1'b1) begin ack_who.push_back(1); ack_cyc.push_back(cyc); end
    if (m0_ack === 1'b1 && m0_req && q0.size() > 0) begin void'(q0.pop_front()); m0_req = 1'b0; end
    if (m1_ack === 1'b1 && m1_req && q1.size() > 0) begin void'(q1.pop_front()); m1_req = 1'b0; end
    if (!m0_req && q0.size() > 0 && (eager || $urandom_range(0, 1) == 1)) begin
      t = q0[0]; m0_req = 1'b1; m0_we = t.we; m0_addr = t.addr; m0_wdata = t.wdata;
    end
    if (!m1_req && q1.size() > 0 && (eager || $urandom_range(0, 1) == 1)) begin
      t = q1[0]; m1_req = 1'b1; m1_we = t.we; m1_addr = t.addr; m1_wdata = t.wdata;
    end
    if (cyc >= idle_at && (m0_req || m1_req)) begin
      if (m0_req && m1_req) w = (last_win == 1'b0) ? 1'b1 : 1'b0;
      else if (m0_req) w = 1'b0;
      else w = 1'b1;
      last_win = w;
      t.we = w ? m1_we : m0_we;
      t.addr = w ? m1_addr : m0_addr;
      t.wdata = w ? m1_wdata : m0_wdata;
      s = (cyc + 1) % 4;
      ring[s].we = t.we; ring[s].a = t.addr; ring[s].d = t.wdata;
      s = (cyc + 2) % 4;
      if (w) ring[s].ack1 = 1'b1; else ring[s].ack0 = 1'b1;
      if (t.we) begin
        ring[s].wr = 1'b1; ring[s].wa = t.addr[3:0]; ring[s].wv = t.wdata;
      end else begin
        if (w) ring[s].upd1 = 1'b1; else ring[s].upd0 = 1'b1;
        ring[s].rdv = shadow[t.addr[3:0]];
      end
      idle_at = cyc + 3;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    s = cyc % 4;
    if (ring[s].upd0) exp_rd0 = ring[s].rdv;
    if (ring[s].upd1) exp_rd1 = ring[s].rdv;
    if (ring[s].wr) shadow[ring[s].wa] = ring[s].wv;
    exp_now = {ring[s].we, ring[s].a, ring[s].d, ring[s].ack0, ring[s].ack1, exp_rd0, exp_rd1};
    ring[s] = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_clear = 1'b1;
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    #2;
    checks++;
    if (observe() !== obs_t'('0)) begin
      errors++; $display("FAIL reset_async: got %h expected 0", observe());
    end
    @(negedge clk); @(negedge clk);
    mem_clear = 1'b0;
    cyc = 0;
    model_reset();
    rst_n = 1'b1;
    repeat (3) begin
      advance(); checks++;
      if (observe() !== exp_now) begin
        errors++; $display("FAIL reset_idle cyc %0d: got %h expected %h", cyc, observe(), exp_now);
      end
    end
  endtask

  task automatic test_tie();
    int start;
    ack_who.delete(); ack_cyc.delete();
    eager = 1'b1;
    q0.push_back('{1'b1, 32'd2, 32'hA});
    q1.push_back('{1'b1, 32'd3, 32'hB});
    start = cyc;
    repeat (8) begin
      advance(); checks++;
      if (observe() !== exp_now) begin
        errors++; $display("FAIL tie cyc %0d: got %h expected %h", cyc, observe(), exp_now);
      end
    end
    checks++;
    if (ack_who.size() != 2 || ack_who[0] != 0 || ack_who[1] != 1 ||
        ack_cyc[0] - start != 2 || ack_cyc[1] - start != 5) begin
      errors++; $display("FAIL tie_order: got %0d acks, required m0@+2 then m1@+5", ack_who.size());
    end
    checks++;
    if (mem_array[2] !== 32'hA || mem_array[3] !== 32'hB) begin
      errors++; $display("FAIL tie_mem: got %h/%h expected a/b", mem_array[2], mem_array[3]);
    end
  endtask

  task automatic test_single_write();
    ack_who.delete(); ack_cyc.delete();
    we_cycles = 0;
    q0.push_back('{1'b1, 32'd1, 32'd4});
    repeat (5) begin
      advance(); checks++;
      if (mem_WE === 1'b1) we_cycles++;
      if (observe() !== exp_now) begin
        errors++; $display("FAIL single_write cyc %0d: got %h expected %h", cyc, observe(), exp_now);
      end
    end
    checks++;
    if (we_cycles != 1 || ack_who.size() != 1 || ack_who[0] != 0 || mem_array[1] !== 32'd4) begin
      errors++; $display("FAIL single_write_summary: we_cycles %0d acks %0d mem1 %h, required 1 1 4", we_cycles, ack_who.size(), mem_array[1]);
    end
  endtask

  task automatic test_read_back();
    we_cycles = 0;
    q0.push_back('{1'b0, 32'd1, 32'd0});
    repeat (5) begin
      advance(); checks++;
      if (mem_WE === 1'b1) we_cycles++;
      if (observe() !== exp_now) begin
        errors++; $display("FAIL read_back cyc %0d: got %h expected %h", cyc, observe(), exp_now);
      end
    end
    checks++;
    if (m0_rdata !== 32'd4 || we_cycles != 0) begin
      errors++; $display("FAIL read_back_data: m0_rdata %h we_cycles %0d, required 4 and 0", m0_rdata, we_cycles);
    end
  endtask

  task automatic test_cross_read();
    q1.push_back('{1'b0, 32'd2, 32'd0});
    repeat (5) begin
      advance(); checks++;
      if (observe() !== exp_now) begin
        errors++; $display("FAIL cross_read cyc %0d: got %h expected %h", cyc, observe(), exp_now);
      end
    end
    checks++;
    if (m1_rdata !== 32'hA || m0_rdata !== 32'd4) begin
      errors++; $display("FAIL cross_read_data: m1 %h m0 %h, required a and 4", m1_rdata, m0_rdata);
    end
  endtask

  task automatic test_contention();
    ack_who.delete(); ack_cyc.delete();
    eager = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q0.push_back('{1'b1, 32'(8 + i), 32'(32'h100 + i)});
      q1.push_back('{1'b0, 32'(2 + (i % 2)), 32'd0});
    end
    repeat (20) begin
      advance(); checks++;
      if (observe() !== exp_now) begin
        errors++; $display("FAIL contention cyc %0d: got %h expected %h", cyc, observe(), exp_now);
      end
    end
    checks++;
    if (ack_who.size() != 6) begin
      errors++; $display("FAIL contention_count: got %0d acks required 6", ack_who.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (ack_who[i] != (i % 2) || (i > 0 && ack_cyc[i] - ack_cyc[i-1] != 3)) begin
          errors++; $display("FAIL contention_order #%0d: got m%0d required m%0d, 3 cycles apart", i, ack_who[i], i % 2);
        end
      end
    end
  endtask

  task automatic test_random();
    int budget;
    eager = 1'b0;
    for (int i = 0; i < 12; i++) begin
      q0.push_back('{1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), 32'($urandom)});
      q1.push_back('{1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), 32'($urandom)});
    end
    budget = 0;
    while (budget < 400 && (q0.size() > 0 || q1.size() > 0 || m0_req || m1_req || cyc < idle_at)) begin
      advance(); checks++; budget++;
      if (observe() !== exp_now) begin
        errors++; $display("FAIL random cyc %0d: got %h expected %h", cyc, observe(), exp_now);
      end
    end
    checks++;
    if (budget >= 400) begin
      errors++; $display("FAIL random_timeout: %0d/%0d transactions left after 400 cycles, required 0", q0.size(), q1.size());
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem_array[i] !== shadow[i]) begin
        errors++; $display("FAIL random_mem[%0d]: got %h expected %h", i, mem_array[i], shadow[i]);
      end
    end
    eager = 1'b1;
  endtask

  task automatic test_reset_mid_access();
    logic [DW-1:0] old5;
    bit            found;
    old5 = mem_array[5];
    found = 1'b0;
    q0.push_back('{1'b1, 32'd5, 32'h55});
    for (int i = 0; i < 8 && !found; i++) begin
      advance(); checks++;
      if (observe() !== exp_now) begin
        errors++; $display("FAIL mid_reset_pre cyc %0d: got %h expected %h", cyc, observe(), exp_now);
      end
      if (exp_now.we) found = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (!found || observe() !== obs_t'('0)) begin
      errors++; $display("FAIL mid_reset_async: reached_access %0d outputs %h expected 0", found, observe());
    end
    m0_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_array[5] !== old5 || m0_ack !== 1'b0 || observe() !== obs_t'('0)) begin
      errors++; $display("FAIL mid_reset_abort: mem5 %h expected %h, outputs %h expected 0", mem_array[5], old5, observe());
    end
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    repeat (3) begin
      advance(); checks++;
      if (observe() !== exp_now) begin
        errors++; $display("FAIL mid_reset_after cyc %0d: got %h expected %h", cyc, observe(), exp_now);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    eager = 1'b1;
    test_reset();
    test_tie();
    test_single_write();
    test_read_back();
    test_cross_read();
    test_contention();
    test_random();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter AW, default 32, address width of requesters and memory.
REQ-002 Parameter DW, default 32, data width of requesters and memory.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 m0_req  input  1  requester 0 (CPU) access request; held until m0_ack.
REQ-006 m0_we  input  1  requester 0 write enable (1 = write, 0 = read); stable while m0_req.
REQ-007 m0_addr  input  AW  requester 0 address; stable while m0_req.
REQ-008 m0_wdata  input  DW  requester 0 write data; stable while m0_req.
REQ-009 m0_ack  output  1  one-cycle completion pulse to requester 0.
REQ-010 m0_rdata  output  DW  registered read data for requester 0.
REQ-011 m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: requester 1 (DMA), same directions, widths and meaning as REQ-005..REQ-010.
REQ-012 mem_A_in  output  AW  address to Data_Mem A_in.
REQ-013 mem_D_in  output  DW  write data to Data_Mem D_in.
REQ-014 mem_WE  output  1  write enable to Data_Mem WE; Data_Mem writes on rising clk when WE=1.
REQ-015 mem_D_out  input  DW  combinational read data from Data_Mem D_out.

Function
REQ-016 FSM states IDLE, ACCESS, RESP; one transaction per pass.
REQ-017 IDLE: if any req, latch winner into grant register, go ACCESS; else stay IDLE.
REQ-018 ACCESS (exactly 1 cycle): drive mem_A_in/mem_D_in/mem_WE from granted requester's addr/wdata/we; go RESP.
REQ-019 ACCESS->RESP edge: if granted we=0, capture mem_D_out into that requester's rdata register; other requester's rdata unchanged; writes leave rdata unchanged.
REQ-020 RESP (exactly 1 cycle): assert ack of granted requester only; go IDLE.
REQ-021 Latency: req sampled in IDLE at cycle N -> ack high in cycle N+2; rdata valid from cycle N+2 until next read by same requester.
REQ-022 Requester drops req on edge ending its ack cycle; req still high in following IDLE is a new request.
REQ-023 Outside ACCESS: mem_WE=0, mem_A_in=0, mem_D_in=0.
REQ-024 mem_WE high for exactly one cycle per write transaction, never for reads.
REQ-025 Arbitration round-robin: last_grant register records last winner; both req in IDLE -> grant requester != last_grant; single req -> grant it regardless of last_grant.
REQ-026 last_grant updates on IDLE->ACCESS edge.
REQ-027 Fairness: with both req continuously high, grants alternate 0,1,0,1...; no requester waits more than one transaction.
REQ-028 Request arriving in ACCESS or RESP is not sampled until next IDLE.
REQ-029 m0_ack and m1_ack never high in same cycle.

Reset
REQ-030 rst_n=0 forces immediately, independent of clk: state IDLE, last_grant=1 (requester 0 wins first tie), grant=0, m0_ack=m1_ack=0, m0_rdata=m1_rdata=0, mem_WE=0, mem_A_in=0, mem_D_in=0.
REQ-031 Reset during ACCESS aborts transaction: mem_WE drops asynchronously, no write at the next edge, no ack issued; requester must re-request.
REQ-032 After rst_n deasserts, first request sampled on first rising edge in IDLE.

Verification
REQ-033 Single write: m0 req we=1 addr=1 wdata=4 -> mem_WE=1, mem_A_in=1, mem_D_in=4 for one cycle; m0_ack at N+2; m1_ack stays 0.
REQ-034 Read-back: after REQ-033, m0 req we=0 addr=1 -> m0_ack at N+2, m0_rdata=4, mem_WE stays 0.
REQ-035 Tie after reset: m0 and m1 req simultaneously (m0 addr=2 wdata=0xA, m1 addr=3 wdata=0xB) -> m0 granted first, then m1; memory holds 2->0xA, 3->0xB; acks in cycles N+2 and N+5.
REQ-036 Continuous contention: both req held for 6 transactions -> ack order 0,1,0,1,0,1, each 3 cycles apart.
REQ-037 Reset mid-access: assert rst_n=0 during ACCESS of write addr=5 wdata=0x55 -> mem_WE=0 immediately, addr 5 unchanged, no ack, all outputs at reset values.
REQ-038 Cross-read isolation: m1 reads addr=2 while m0_rdata=4 -> m1_rdata=0xA, m0_rdata remains 4.
